// File: rtl/apb_pkg.sv
// apb_pkg: shared APB state, command/response types and bus constants
package apb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } apb_cmd_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } apb_rsp_t;

    localparam logic [2:0] APB_PROT_DEFAULT = 3'b000;
    localparam logic [3:0] APB_STRB_READ    = 4'b0000;

endpackage

// File: rtl/apb_psel_decode.sv
// apb_psel_decode: slave index field to one-hot psel with out-of-range flag
module apb_psel_decode #(
    parameter int NSLV  = 16,
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0] idx,
    output logic [NSLV-1:0]  sel,
    output logic             oor
);

    // Indices beyond the last slave select nothing and flag an error
    always_comb begin
        oor = int'(idx) >= NSLV;
        sel = oor ? '0 : NSLV'(1) << idx;
    end

endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: valid/ready command stream to APB4 initiator with pready timeout
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 16,
    parameter int SEL_LSB = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [NSLV-1:0]   psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [31:0]       pwdata,
    output logic [3:0]        pstrb,
    output logic [2:0]        pprot,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int SEL_W = NSLV > 1 ? $clog2(NSLV) : 1;

    if (DATA_W != 32) begin : g_bad_data_w
        $error("apb_cmd_master: DATA_W must be 32");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("apb_cmd_master: TIMEOUT must be 1..255");
    end

    apb_state_e      state, state_nx;
    apb_cmd_t        cmd_q;
    apb_rsp_t        rsp_q;
    logic            up;
    logic [7:0]      wait_cnt;
    logic [NSLV-1:0] sel;
    logic            sel_oor, accept, misalign, expire, on_bus;

    // up keeps cmd_ready low until the first edge after reset release
    assign cmd_ready   = up && state == IDLE;
    assign accept      = cmd_valid && cmd_ready;
    assign misalign    = |cmd_addr[1:0];
    assign expire      = !pready && wait_cnt == 8'(TIMEOUT - 1);
    assign on_bus      = state == SETUP || state == ACCESS;
    assign pwrite      = cmd_q.write;
    assign pwdata      = cmd_q.wdata;
    assign pstrb       = cmd_q.strb;
    assign pprot       = APB_PROT_DEFAULT;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

    apb_psel_decode #(.NSLV(NSLV), .SEL_W(SEL_W)) u_dec (
        .idx (paddr[SEL_LSB +: SEL_W]),
        .sel (sel),
        .oor (sel_oor)
    );

    // State register; reset drops the bus at once since psel/penable decode from state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and bus/response strobes
    always_comb begin
        state_nx = state;
        psel     = on_bus ? sel : '0;
        penable  = state == ACCESS;
        rsp_valid = state == RESP;
        case (state)
            IDLE:    state_nx = accept ? (misalign ? RESP : SETUP) : IDLE;
            SETUP:   state_nx = sel_oor ? RESP : ACCESS;
            ACCESS:  state_nx = (pready || expire) ? RESP : ACCESS;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Command capture, wait-state counter and response registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            up       <= 1'b0;
            paddr    <= '0;
            cmd_q    <= '0;
            rsp_q    <= '0;
            wait_cnt <= '0;
        end else begin
            up <= 1'b1;
            if (accept) begin
                paddr    <= {cmd_addr[ADDR_W-1:2], 2'b00};
                cmd_q    <= '{write: cmd_write, wdata: cmd_wdata,
                              strb: cmd_write ? cmd_strb : APB_STRB_READ};
                rsp_q    <= '{rdata: 32'd0, err: misalign, timeout: 1'b0};
                wait_cnt <= '0;
            end
            if (state == SETUP && sel_oor) rsp_q.err <= 1'b1;
            if (state == ACCESS) begin
                if (pready)
                    rsp_q <= '{rdata: cmd_q.write ? 32'd0 : prdata, err: pslverr, timeout: 1'b0};
                else if (expire)
                    rsp_q <= '{rdata: 32'd0, err: 1'b1, timeout: 1'b1};
                if (!pready) wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule
